// File: rtl/rat_pkg.sv
// rat_pkg: constants and types shared by the rational arithmetic blocks.
// Provides the default operand width and a {num, den} rational pair type.
package rat_pkg;

    localparam int RAT_WIDTH = 32;

    typedef struct packed {
        logic [RAT_WIDTH-1:0] num;
        logic [RAT_WIDTH-1:0] den;
    } rat_t;

endpackage

// File: rtl/rat_div_if.sv
// rat_div_if: operand/result bundle for one rational divide lane.
// Ports: l_num, l_den, r_num, r_den (operands), s_num, s_den (result).
interface rat_div_if
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
);

    logic [WIDTH-1:0] l_num;
    logic [WIDTH-1:0] l_den;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] s_num;
    logic [WIDTH-1:0] s_den;

    // master supplies operands and consumes the result
    modport master (
        output l_num, l_den, r_num, r_den,
        input  s_num, s_den
    );

    // slave is the divider itself
    modport slave (
        input  l_num, l_den, r_num, r_den,
        output s_num, s_den
    );

endinterface

// File: rtl/rat_mul_lo.sv
// rat_mul_lo: combinational unsigned WIDTH x WIDTH multiply, low WIDTH bits.
// Ports: a, b (operands), p (a*b mod 2^WIDTH).
module rat_mul_lo
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // Context width is WIDTH, so the product wraps modulo 2^WIDTH.
    assign p = a * b;

endmodule

// File: rtl/rat_div.sv
// rat_div: (l_num/l_den)/(r_num/r_den) by cross-multiply, one register stage.
// Ports: clk, rst_n, l_num/l_den/r_num/r_den in, s_num/s_den registered out.
module rat_div
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den
);

    logic [WIDTH-1:0] num_p;
    logic [WIDTH-1:0] den_p;

    rat_mul_lo #(.WIDTH(WIDTH)) u_num (
        .a (l_num),
        .b (r_den),
        .p (num_p)
    );

    rat_mul_lo #(.WIDTH(WIDTH)) u_den (
        .a (l_den),
        .b (r_num),
        .p (den_p)
    );

    // Result is the raw unreduced pair; zero operands are not flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_num <= '0;
            s_den <= '0;
        end else begin
            s_num <= num_p;
            s_den <= den_p;
        end
    end

endmodule

// File: tb/tb_rat_div.sv
// tb_rat_div: directed and random checks of the rat_div cross-multiplier.
// Drives operands through rat_div_if and checks results one edge later.
module tb_rat_div;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    rat_div_if #(.WIDTH(32)) bus ();

    rat_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .l_num (bus.l_num),
        .l_den (bus.l_den),
        .r_num (bus.r_num),
        .r_den (bus.r_den),
        .s_num (bus.s_num),
        .s_den (bus.s_den)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ln, input logic [31:0] ld,
                         input logic [31:0] rn, input logic [31:0] rd);
        bus.l_num = ln;
        bus.l_den = ld;
        bus.r_num = rn;
        bus.r_den = rd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b_ln [8];
    logic [31:0] b_ld [8];
    logic [31:0] b_rn [8];
    logic [31:0] b_rd [8];
    logic [31:0] b_sn [8];
    logic [31:0] b_sd [8];

    initial begin
        logic [31:0] ln, ld, rn, rd;
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        drive(32'd3, 32'd4, 32'd5, 32'd7);

        // reset holds outputs at zero even across edges
        step();
        check("rst_num", bus.s_num, 32'd0);
        check("rst_den", bus.s_den, 32'd0);

        #2 rst_n = 1'b1;

        // basic: (3/4)/(5/7) -> 21/20
        step();
        check("basic_num", bus.s_num, 32'd21);
        check("basic_den", bus.s_den, 32'd20);

        // zero operands
        drive(32'd0, 32'd9, 32'd0, 32'd4);
        step();
        check("zero_num", bus.s_num, 32'd0);
        check("zero_den", bus.s_den, 32'd0);

        drive(32'd2, 32'd3, 32'd5, 32'd0);
        step();
        check("rden0_num", bus.s_num, 32'd0);
        check("rden0_den", bus.s_den, 32'd15);

        // wrap-around
        drive(32'h0001_0000, 32'hFFFF_FFFF, 32'd2, 32'h0001_0000);
        step();
        check("wrap_num", bus.s_num, 32'd0);
        check("wrap_den", bus.s_den, 32'hFFFF_FFFE);

        // independence: num path ignores l_den/r_num
        drive(32'd11, 32'd0, 32'd0, 32'd13);
        step();
        check("ind_num", bus.s_num, 32'd143);
        check("ind_den", bus.s_den, 32'd0);

        // async reset mid-cycle
        drive(32'd6, 32'd1, 32'd1, 32'd7);
        step();
        check("pre_rst_num", bus.s_num, 32'd42);
        check("pre_rst_den", bus.s_den, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_num", bus.s_num, 32'd0);
        check("async_den", bus.s_den, 32'd0);
        step();
        check("held_num", bus.s_num, 32'd0);
        check("held_den", bus.s_den, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_num", bus.s_num, 32'd42);
        check("post_rst_den", bus.s_den, 32'd1);

        // back-to-back, new operands every cycle
        b_ln = '{32'd1, 32'd5, 32'd9, 32'd13,
                 32'd100, 32'd0, 32'd255, 32'd1000};
        b_ld = '{32'd2, 32'd6, 32'd10, 32'd14,
                 32'd200, 32'd1, 32'd256, 32'd999};
        b_rn = '{32'd3, 32'd7, 32'd11, 32'd15,
                 32'd300, 32'd1, 32'd257, 32'd998};
        b_rd = '{32'd4, 32'd8, 32'd12, 32'd16,
                 32'd400, 32'd0, 32'd258, 32'd997};
        b_sn = '{32'd4, 32'd40, 32'd108, 32'd208,
                 32'd40000, 32'd0, 32'd65790, 32'd997000};
        b_sd = '{32'd6, 32'd42, 32'd110, 32'd210,
                 32'd60000, 32'd1, 32'd65792, 32'd997002};
        for (int i = 0; i < 8; i++) begin
            drive(b_ln[i], b_ld[i], b_rn[i], b_rd[i]);
            step();
            check($sformatf("b2b%0d_num", i), bus.s_num, b_sn[i]);
            check($sformatf("b2b%0d_den", i), bus.s_den, b_sd[i]);
        end

        // random small operands
        for (int i = 0; i < 24; i++) begin
            ln = 32'($urandom_range(999, 0));
            ld = 32'($urandom_range(999, 0));
            rn = 32'($urandom_range(999, 0));
            rd = 32'($urandom_range(999, 0));
            drive(ln, ld, rn, rd);
            step();
            check($sformatf("rnd%0d_num", i), bus.s_num, ln * rd);
            check($sformatf("rnd%0d_den", i), bus.s_den, ld * rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
